pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 107 ++++++++++
 tb/tb_pipelined_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked ripple-carry adder, one CHUNK per stage, valid/ready handshake
// Each stage adds its chunk and forwards the remaining operand bits plus the finished low sum bits.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int L = WIDTH / CHUNK;

  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a positive integer multiple of CHUNK");
  end

  logic advance;
  logic last_valid;

  assign out_valid = last_valid && !rst;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < L; k++) begin : g_st
    localparam int DONE = k * CHUNK;
    localparam int TODO = WIDTH - DONE;

    logic [TODO-1:0]       op_a;
    logic [TODO-1:0]       op_b;
    logic                  carry_in;
    logic                  valid_in;
    logic [CHUNK:0]        part;
    logic [DONE+CHUNK-1:0] s_d;
    logic [DONE+CHUNK-1:0] s_q;
    logic                  c_q;
    logic                  v_q;

    if (k == 0) begin : g_head
      assign op_a     = a;
      assign op_b     = b;
      assign carry_in = cin;
      assign valid_in = in_valid;
      assign s_d      = part[CHUNK-1:0];
    end else begin : g_body
      assign op_a     = g_st[k-1].g_fwd.ra_q;
      assign op_b     = g_st[k-1].g_fwd.rb_q;
      assign carry_in = g_st[k-1].c_q;
      assign valid_in = g_st[k-1].v_q;
      assign s_d      = {part[CHUNK-1:0], g_st[k-1].s_q};
    end

    assign part = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_in};

    // Data registers only load with a real transaction, so outputs keep their last value across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= valid_in;
        if (valid_in) begin
          c_q <= part[CHUNK];
          s_q <= s_d;
        end
      end
    end

    if (k < L - 1) begin : g_fwd
      logic [TODO-CHUNK-1:0] ra_q;
      logic [TODO-CHUNK-1:0] rb_q;

      always_ff @(posedge clk) begin
        if (advance && valid_in) begin
          ra_q <= op_a[TODO-1:CHUNK];
          rb_q <= op_b[TODO-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Carry into the MSB is recovered as a^b^sum at that bit, then xored with the carry out.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance && valid_in) begin
          ovf_q <= op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ part[CHUNK-1] ^ part[CHUNK];
        end
      end
    end
  end

  assign last_valid = g_st[L-1].v_q;
  assign sum        = g_st[L-1].s_q;
  assign cout       = g_st[L-1].c_q;
  assign ovf        = g_st[L-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - randomized and directed checks of pipelined_adder against an arithmetic model
module tb_pipelined_adder;
  localparam int L = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  bit          chk_lat = 1'b0;
  logic [33:0] exp_q[$];
  int          acc_q[$];

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ovf, cout, sum} from plain 33-bit arithmetic and the sign rule for overflow.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {32'd0, c};
    v = (x[31] == y[31]) && (t[31] != x[31]);
    return {v, t[32], t[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive, check outputs, update the model, then advance one clock.
  task automatic cycle(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                       input logic cc, input logic ordy, output logic acc);
    logic [33:0] e;
    in_valid  = v;
    a         = aa;
    b         = bb;
    cin       = cc;
    out_ready = ordy;
    #1;
    acc = v && in_ready && !rst;
    if (chk_lat && exp_q.size() > 0 && (cyc - acc_q[0]) == L)
      chk("due_out_valid", 64'(out_valid), 64'd1);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        if (chk_lat) chk("latency", 64'(cyc - acc_q[0]), 64'(L));
        e = exp_q.pop_front();
        void'(acc_q.pop_front());
        chk("sum", 64'(sum), 64'(e[31:0]));
        chk("cout", 64'(cout), 64'(e[32]));
        chk("ovf", 64'(ovf), 64'(e[33]));
      end
    end else if (out_valid && !out_ready) begin
      stall_cnt++;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (exp_q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      else chk("held_result", 64'({ovf, cout, sum}), 64'(exp_q[0]));
    end
    if (acc) begin
      exp_q.push_back(ref_add(aa, bb, cc));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag);
    logic acc;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++)
      cycle(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, acc);
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic [31:0] da[6] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
  logic [31:0] db[6] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 32'h8765_4321};
  logic        dc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic        acc;
    logic [31:0] ra;
    logic [31:0] rb;
    int          idx;
    int          t;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);

    // Directed single operations, each drained before the next.
    chk_lat = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, da[i], db[i], dc[i], 1'b1, acc);
      chk("directed_accept", 64'(acc), 64'd1);
      drain("directed");
    end
    chk("hold_after_idle_sum", 64'(sum), 64'(ref_add(da[5], db[5], dc[5]) & 34'h0_FFFF_FFFF));

    // Back-to-back streaming at full rate.
    for (int i = 0; i < 100; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
      cycle(1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'b1, acc);
      if (i == 0 || i == 99) chk("stream_accept", 64'(acc), 64'd1);
    end
    drain("stream");

    // Backpressure: 4 fill cycles then 5 stalled cycles with out_ready low.
    chk_lat = 1'b0;
    stall_cnt = 0;
    idx = 0;
    t = 0;
    while ((idx < 6 || exp_q.size() > 0) && t < 60) begin
      cycle(idx < 6, $urandom, $urandom, 1'($urandom_range(0, 1)), t >= 9, acc);
      if (acc) idx++;
      t++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd6);
    chk("bp_all_delivered", 64'(exp_q.size()), 64'd0);
    chk("bp_stall_cycles", 64'(stall_cnt), 64'd5);

    // Random valid and ready patterns.
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), acc);
    drain("random");

    // Reset while three operations are in flight.
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, acc);
      chk("pre_rst_accept", 64'(acc), 64'd1);
    end
    rst = 1'b1;
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1, acc);
    chk("rst_no_accept", 64'(acc), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
      cycle(1'b0, $urandom, $urandom, 1'b0, 1'b1, acc);
    end
    cycle(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, acc);
    chk("post_rst_accept", 64'(acc), 64'd1);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
